// File: rtl/fpu_add_pkg.sv
// ---------------------------------------------------------------------------
// fpu_add_pkg
// Shared types and constants for the single-precision FP add issue stage:
// sequencer states, rounding-mode encodings, binary32 field widths, the
// canonical quiet NaN, operand classes and fflags bit positions.
// ---------------------------------------------------------------------------
package fpu_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Rounding-mode encodings; 5 and 6 are reserved, 7 selects the CSR value.
   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;
   localparam logic [2:0] RM_DYN = 3'd7;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam int FP_W   = 1 + EXP_W + MANT_W;

   localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

   // fflags = {NV, DZ, OF, UF, NX}
   localparam int FFLAG_W  = 5;
   localparam int FFLAG_NV = 4;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_NX = 0;

   // Operand classes produced by fpu_add_classify (subnormals are FINITE).
   typedef enum logic [2:0] {
      CLS_FINITE = 3'd0,
      CLS_ZERO   = 3'd1,
      CLS_INF    = 3'd2,
      CLS_SNAN   = 3'd3,
      CLS_QNAN   = 3'd4
   } fp_class_t;

   function automatic logic [2:0] rm_resolve(input logic [2:0] rm, input logic [2:0] dyn);
      return (rm == RM_DYN) ? dyn : rm;
   endfunction

   function automatic logic rm_is_legal(input logic [2:0] rm);
      return rm <= RM_RMM;
   endfunction

endpackage

// File: rtl/fpu_add_classify.sv
// ---------------------------------------------------------------------------
// fpu_add_classify
// Purely combinational classification of one binary32 operand.
//   op   in  32 : operand
//   sign out 1  : sign bit
//   cls  out 3  : fp_class_t code (FINITE, ZERO, INF, SNAN, QNAN)
// ---------------------------------------------------------------------------
module fpu_add_classify
   import fpu_add_pkg::*;
(
   input  logic [FP_W-1:0] op,
   output logic            sign,
   output logic [2:0]      cls
);

   logic [EXP_W-1:0]  exp_f;
   logic [MANT_W-1:0] mant_f;

   assign sign   = op[FP_W-1];
   assign exp_f  = op[FP_W-2:MANT_W];
   assign mant_f = op[MANT_W-1:0];

   always_comb begin
      // NOTE: default assigned first so every path drives cls and no latch is inferred.
      cls = CLS_FINITE;
      if (exp_f == '1) begin
         if (mant_f == '0)
            cls = CLS_INF;
         else if (mant_f[MANT_W-1])
            cls = CLS_QNAN;
         else
            cls = CLS_SNAN;
      end else if (exp_f == '0 && mant_f == '0) begin
         cls = CLS_ZERO;
      end
   end

endmodule

// File: rtl/fpu_add_issue.sv
// ---------------------------------------------------------------------------
// fpu_add_issue
// Request sequencer in front of the binary32 adder. Accepts FADD/FSUB over
// valid/ready, resolves the dynamic rounding mode, folds FSUB into a sign
// flip of B, computes NV, fires a one-cycle add_req and holds the adder's
// result in a response register until writeback takes it.
//   clk, rst_n                     : clock, async active-low reset
//   req_valid/req_ready            : request handshake
//   req_op, req_rm, req_a, req_b,
//   req_tag, frm                   : request payload, CSR rounding mode
//   add_req, add_rm, add_a, add_b  : adder request (add_b has effective sign)
//   add_valid, add_out             : adder result, one cycle after add_req
//   rsp_valid/rsp_ready            : response handshake
//   rsp_result, rsp_tag,
//   rsp_fflags, rsp_illegal        : response payload
//   protocol_err                   : sticky, add_valid seen outside WAIT
// ---------------------------------------------------------------------------
module fpu_add_issue
   import fpu_add_pkg::*;
#(
   parameter int FP_SIZE = 32,
   parameter int TAG_W   = 5
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_op,
   input  logic [2:0]         req_rm,
   input  logic [FP_SIZE-1:0] req_a,
   input  logic [FP_SIZE-1:0] req_b,
   input  logic [TAG_W-1:0]   req_tag,
   input  logic [2:0]         frm,
   output logic               add_req,
   output logic [2:0]         add_rm,
   output logic [FP_SIZE-1:0] add_a,
   output logic [FP_SIZE-1:0] add_b,
   input  logic               add_valid,
   input  logic [FP_SIZE-1:0] add_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [FP_SIZE-1:0] rsp_result,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic [4:0]         rsp_fflags,
   output logic               rsp_illegal,
   output logic               protocol_err
);

   state_t             state_q, state_d;
   logic [FP_SIZE-1:0] a_q, b_q, result_q, b_eff;
   logic [2:0]         rm_q, rm_res;
   logic [TAG_W-1:0]   tag_q;
   logic               nv_q, illegal_q, perr_q;
   logic               rm_ok, accept, nv_calc;
   logic               sign_a, sign_b;
   logic [2:0]         cls_a, cls_b;

   // FSUB becomes an add of -B; classification and NV use this effective B.
   assign b_eff     = req_b ^ {req_op, {(FP_SIZE-1){1'b0}}};
   assign rm_res    = rm_resolve(req_rm, frm);
   assign rm_ok     = rm_is_legal(rm_res);
   assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready);
   assign accept    = req_valid && req_ready;

   fpu_add_classify u_cls_a (.op(req_a), .sign(sign_a), .cls(cls_a));
   fpu_add_classify u_cls_b (.op(b_eff), .sign(sign_b), .cls(cls_b));

   assign nv_calc = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN) ||
                    (cls_a == CLS_INF && cls_b == CLS_INF && sign_a != sign_b);

   // An illegal rm skips the adder and lands straight in RESP; leaving RESP
   // with a new accept avoids an idle bubble.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = rm_ok ? ST_ISSUE : ST_RESP;
      end else begin
         case (state_q)
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (add_valid) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset as well, so add_* and rsp_* read 0 out of reset.
         a_q       <= '0;
         b_q       <= '0;
         rm_q      <= RM_RNE;
         tag_q     <= '0;
         nv_q      <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
         perr_q    <= 1'b0;
      end else begin
         if (accept) begin
            a_q       <= req_a;
            b_q       <= b_eff;
            // Keep add_rm a legal encoding even when the request is rejected.
            rm_q      <= rm_ok ? rm_res : RM_RNE;
            tag_q     <= req_tag;
            nv_q      <= rm_ok && nv_calc;
            illegal_q <= !rm_ok;
            if (!rm_ok)
               result_q <= '0;
         end
         if (state_q == ST_WAIT && add_valid)
            result_q <= add_out;
         if (add_valid && state_q != ST_WAIT)
            perr_q <= 1'b1;
      end
   end

   assign add_req      = (state_q == ST_ISSUE);
   assign add_a        = a_q;
   assign add_b        = b_q;
   assign add_rm       = rm_q;
   assign rsp_valid    = (state_q == ST_RESP);
   assign rsp_result   = result_q;
   assign rsp_tag      = tag_q;
   assign rsp_illegal  = illegal_q;
   assign protocol_err = perr_q;

   always_comb begin
      rsp_fflags           = '0;
      rsp_fflags[FFLAG_NV] = nv_q;
   end

endmodule

// File: tb/tb_fpu_add_issue.sv
// ---------------------------------------------------------------------------
// tb_fpu_add_issue
// Scoreboard bench: the stimulus process pushes expected adder requests and
// responses when a request is accepted; an adder stand-in checks and pops
// the adder-request queue, and a response monitor checks and pops the
// response queue. Inputs change on the falling edge, outputs are sampled
// a little after it.
// ---------------------------------------------------------------------------
module tb_fpu_add_issue;
   import fpu_add_pkg::*;

   localparam int TAG_W = 5;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_op;
   logic [2:0]  req_rm, frm;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_tag;
   logic        add_req, add_valid;
   logic [2:0]  add_rm;
   logic [31:0] add_a, add_b, add_out;
   logic        rsp_valid, rsp_ready, rsp_illegal, protocol_err;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_tag, rsp_fflags;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rm;
      int          cyc;
   } iss_t;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  tag;
      logic [4:0]  ff;
      logic        ill;
      int          cyc;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int inj_cnt = 0;
   int ready_mode = 0;
   int stall_cnt = 0;
   logic hold = 1'b0;

   fpu_add_issue #(.FP_SIZE(32), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rm(req_rm), .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .frm(frm),
      .add_req(add_req), .add_rm(add_rm), .add_a(add_a), .add_b(add_b),
      .add_valid(add_valid), .add_out(add_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
      .protocol_err(protocol_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h required %08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got event required none at t=%0t", name, $time);
   endtask

   // Adder stand-in: the two values from the worked examples, otherwise a
   // scramble of the operands so every result is distinguishable.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm);
      if (a == 32'h3FA0_0000 && b == 32'h3FB0_0000) return 32'h4028_0000;
      if (a == 32'h3FA0_0000 && b == 32'hBFA0_0000) return 32'h0000_0000;
      return (a ^ {b[15:0], b[31:16]}) + {29'b0, rm};
   endfunction

   function automatic logic is_snan(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 23'd0 && !x[22];
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return x[30:0] == 31'h7F80_0000;
   endfunction

   // Reference model: what the accepted request must turn into.
   task automatic model_accept(input logic op, input logic [2:0] rm, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      logic [31:0] eb;
      logic [2:0]  rr;
      logic        ill, nv;
      iss_t        it;
      rsp_t        rt;
      eb = b;
      if (op) eb[31] = ~b[31];
      rr  = (rm == RM_DYN) ? f : rm;
      ill = (rr > RM_RMM);
      nv  = is_snan(a) || is_snan(eb) || (is_inf(a) && is_inf(eb) && a[31] != eb[31]);
      // accept edge is cyc+1; add_req in cycle N+1, response from N+3 (N+1 if illegal)
      if (!ill) begin
         it.a = a; it.b = eb; it.rm = rr; it.cyc = cyc + 2;
         iss_q.push_back(it);
      end
      rt.result = ill ? 32'd0 : ref_add(a, eb, rr);
      rt.tag    = tag;
      rt.ff     = 5'd0;
      if (!ill) rt.ff[FFLAG_NV] = nv;
      rt.ill    = ill;
      rt.cyc    = ill ? cyc + 2 : cyc + 4;
      rsp_q.push_back(rt);
   endtask

   task automatic pick_ready();
      if (ready_mode == 0) begin
         rsp_ready = 1'b1;
      end else if (ready_mode == 1) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
      end else if (!rsp_valid) begin
         stall_cnt = 0;
         rsp_ready = 1'b1;
      end else if (stall_cnt < 4) begin
         stall_cnt++;
         rsp_ready = 1'b0;
      end else begin
         stall_cnt = 0;
         rsp_ready = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      pick_ready();
   endtask

   task automatic issue(input logic op, input logic [2:0] rm, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      bit done = 1'b0;
      req_valid = 1'b1; req_op = op; req_rm = rm; frm = f;
      req_a = a; req_b = b; req_tag = tag;
      for (int g = 0; g < 100 && !done; g++) begin
         #1;
         if (rsp_valid && rsp_ready) check("ready_on_rsp_handshake", {31'd0, req_ready}, 32'd1);
         if (req_ready) begin
            model_accept(op, rm, f, a, b, tag);
            done = 1'b1;
         end
         @(negedge clk);
         pick_ready();
      end
      req_valid = 1'b0;
      frm = 3'($urandom);
      if (!done) fail_now("accept_timeout");
   endtask

   task automatic drain();
      int g = 0;
      while ((rsp_q.size() != 0 || iss_q.size() != 0 || rsp_valid) && g < 300) begin
         tick();
         g++;
      end
      if (g >= 300) fail_now("drain_timeout");
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 9))
         0: return 32'h7F80_0000;
         1: return 32'hFF80_0000;
         2: return {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
         3: return QNAN;
         4: return {x[31], 31'd0};
         5: return 32'h3FA0_0000;
         default: return x;
      endcase
   endfunction

   // Adder stand-in: checks each add_req against the model, answers one
   // cycle later unless held off; also injects stray add_valid pulses.
   initial begin
      logic        pend, inj;
      logic [31:0] pa, pb;
      logic [2:0]  prm;
      int          seen;
      iss_t        it;
      add_valid = 1'b0;
      add_out   = 32'd0;
      seen      = 0;
      forever begin
         @(negedge clk);
         #2;
         pend = 1'b0;
         if (rst_n && add_req) begin
            if (iss_q.size() == 0) begin
               fail_now("unexpected_add_req");
            end else begin
               it = iss_q.pop_front();
               check("add_req_cycle", cyc + 1, it.cyc);
               check("add_a", add_a, it.a);
               check("add_b", add_b, it.b);
               check("add_rm", {29'd0, add_rm}, {29'd0, it.rm});
            end
            pend = !hold;
         end
         pa = add_a; pb = add_b; prm = add_rm;
         inj  = (inj_cnt != seen);
         seen = inj_cnt;
         @(posedge clk);
         #1;
         add_valid = pend || inj;
         add_out   = pend ? ref_add(pa, pb, prm) : $urandom;
      end
   end

   // Response monitor.
   initial begin
      logic prev_v, prev_hs;
      rsp_t e;
      prev_v  = 1'b0;
      prev_hs = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (rsp_valid) begin
               if (rsp_q.size() == 0) begin
                  if (!prev_v || prev_hs) fail_now("unexpected_rsp");
               end else begin
                  e = rsp_q[0];
                  if (!prev_v || prev_hs) begin
                     check("rsp_latency", cyc + 1, e.cyc);
                     check("rsp_result", rsp_result, e.result);
                     check("rsp_tag", {27'd0, rsp_tag}, {27'd0, e.tag});
                     check("rsp_fflags", {27'd0, rsp_fflags}, {27'd0, e.ff});
                     check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
                  end else begin
                     check("held_result", rsp_result, e.result);
                     check("held_tag", {27'd0, rsp_tag}, {27'd0, e.tag});
                     check("held_fflags", {27'd0, rsp_fflags}, {27'd0, e.ff});
                     check("held_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
                  end
                  if (rsp_ready) void'(rsp_q.pop_front());
               end
            end else if (prev_v && !prev_hs) begin
               fail_now("rsp_dropped_without_handshake");
            end
            prev_v  = rsp_valid;
            prev_hs = rsp_valid && rsp_ready;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_add_req"}, {31'd0, add_req}, 32'd0);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
      check({tag, "_protocol_err"}, {31'd0, protocol_err}, 32'd0);
      check({tag, "_add_a"}, add_a, 32'd0);
      check({tag, "_add_b"}, add_b, 32'd0);
      check({tag, "_add_rm"}, {29'd0, add_rm}, 32'd0);
      check({tag, "_rsp_result"}, rsp_result, 32'd0);
      check({tag, "_rsp_tag"}, {27'd0, rsp_tag}, 32'd0);
      check({tag, "_rsp_fflags"}, {27'd0, rsp_fflags}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_rm = 3'd0; frm = 3'd0;
      req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0; rsp_ready = 1'b1;
      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Worked examples.
      issue(1'b0, RM_RNE, 3'd0,   32'h3FA0_0000, 32'h3FB0_0000, 5'd5);
      issue(1'b1, RM_DYN, RM_RTZ, 32'h3FA0_0000, 32'h3FA0_0000, 5'd6);
      issue(1'b0, RM_RNE, 3'd0,   32'h7F80_0000, 32'hFF80_0000, 5'd7);
      issue(1'b1, RM_RUP, 3'd0,   32'h7F80_0000, 32'h7F80_0000, 5'd8);
      issue(1'b0, RM_RDN, 3'd0,   32'h7F80_0001, 32'h3F80_0000, 5'd9);
      issue(1'b0, RM_RMM, 3'd0,   QNAN,          32'h3F80_0000, 5'd10);
      issue(1'b0, RM_DYN, 3'd5,   32'h3F80_0000, 32'h3F80_0000, 5'd11);
      issue(1'b0, 3'd6,   3'd0,   32'h3F80_0000, 32'h3F80_0000, 5'd12);
      drain();

      // Back-to-back with writeback stalling 4 cycles per response.
      ready_mode = 2;
      issue(1'b0, RM_RNE, 3'd0, 32'h4000_0000, 32'h4040_0000, 5'd13);
      issue(1'b1, RM_RTZ, 3'd0, 32'h4080_0000, 32'h3F80_0000, 5'd14);
      issue(1'b0, RM_DYN, 3'd7, 32'h4080_0000, 32'h3F80_0000, 5'd15);
      issue(1'b0, RM_RNE, 3'd0, 32'hC000_0000, 32'h7F80_0001, 5'd16);
      drain();

      // Randomised traffic with random writeback back-pressure.
      ready_mode = 1;
      for (int i = 0; i < 300; i++) begin
         int          r;
         logic [2:0]  rm, f;
         while ($urandom_range(0, 3) == 0) tick();
         r  = $urandom_range(0, 9);
         rm = (r <= 6) ? 3'(r) : RM_DYN;
         f  = 3'($urandom);
         issue(1'($urandom), rm, f, rand_operand(), rand_operand(), 5'($urandom));
      end
      ready_mode = 0;
      drain();
      check("no_protocol_err_in_normal_run", {31'd0, protocol_err}, 32'd0);

      // Reset while the adder result is outstanding.
      hold = 1'b1;
      issue(1'b0, RM_RNE, 3'd0, 32'h4000_0000, 32'h3F80_0000, 5'd20);
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      iss_q.delete();
      rsp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hold  = 1'b0;
      repeat (8) tick();
      check("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);

      // Stray add_valid while idle.
      inj_cnt++;
      repeat (3) tick();
      check("protocol_err_set", {31'd0, protocol_err}, 32'd1);
      repeat (5) tick();
      check("protocol_err_sticky", {31'd0, protocol_err}, 32'd1);
      check("stray_valid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      #3;
      rst_n = 1'b0;
      #1;
      check("protocol_err_cleared", {31'd0, protocol_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_add_issue.md
# fpu_add_issue

Request sequencer sitting directly upstream of the single-precision FP adder. It accepts FADD/FSUB requests from the core over a valid/ready handshake and resolves the dynamic rounding mode. It converts FSUB into an addition with a sign-flipped B and computes the invalid-operation flag. It then drives the adder's one-shot request and captures the adder's one-cycle-later result into a held response register for writeback.

## Interface
- `FP_SIZE`, 32: operand and result width (binary32 only).
- `TAG_W`, 5: width of the destination/ROB tag carried alongside the request.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request this cycle.
- `req_op`  in  1: 0 = FADD, 1 = FSUB.
- `req_rm`  in  3: instruction rounding mode; 3'b111 = dynamic.
- `req_a`, `req_b`  in  FP_SIZE: operands.
- `req_tag`  in  TAG_W: tag, returned unchanged.
- `frm`  in  3: CSR dynamic rounding mode, sampled at request acceptance.
- `add_req`  out  1: request strobe to the adder; one cycle wide.
- `add_rm`  out  3: resolved rounding mode, never 3'b111.
- `add_a`, `add_b`  out  FP_SIZE: adder operands; `add_b` carries the effective sign.
- `add_valid`  in  1: adder result valid.
- `add_out`  in  FP_SIZE: adder result.
- `rsp_valid`  out  1: response held.
- `rsp_ready`  in  1: writeback accepts the response.
- `rsp_result`  out  FP_SIZE: result; 0 when illegal.
- `rsp_tag`  out  TAG_W: tag of the request.
- `rsp_fflags`  out  5: {NV,DZ,OF,UF,NX}; only NV is driven, the rest are 0.
- `rsp_illegal`  out  1: rounding mode was illegal; the adder was not used.
- `protocol_err`  out  1: sticky; set when `add_valid` is seen outside WAIT.

## Operation
- Four states:
  - IDLE: waiting for a request.
  - ISSUE: `add_req`=1 with the registered operands.
  - WAIT: waiting for `add_valid`.
  - RESP: `rsp_valid`=1, response held stable.
- Request acceptance:
  - `req_ready` = (state==IDLE) | (state==RESP & `rsp_ready`).
  - On accept, the block registers `req_a`, `req_b`^{op,31'b0}, `req_tag`, and the resolved rm.
  - Resolved rm: if `req_rm`==3'b111 it is `frm`, otherwise `req_rm`.
- Illegal rounding mode: the resolved rm is 3'b101, 3'b110 or 3'b111. The block bypasses the adder and loads RESP directly with `rsp_illegal`=1, `rsp_result`=0, `rsp_fflags`=0.
- Legal path transitions:
  - accept → ISSUE;
  - ISSUE → WAIT unconditionally;
  - WAIT with `add_valid` → RESP, capturing `add_out`;
  - WAIT without `add_valid` stays in WAIT.
- RESP:
  - with `rsp_ready` and no new accept → IDLE;
  - with `rsp_ready` and a simultaneous accept → ISSUE, or RESP again for an illegal rm, with no idle bubble;
  - without `rsp_ready`, all `rsp_*` outputs stay stable.
- NV is computed at accept from the raw A and effective B and is carried to the response. NV=1 when either of the following holds:
  - either operand is a signalling NaN (exp==8'hFF, mant!=0, mant[22]==0);
  - both operands are infinite with opposite effective signs.
- `add_a`, `add_b` and `add_rm` are driven from the registers in every state. `add_req` is 1 only in ISSUE.
- `add_valid` arriving in IDLE, ISSUE or RESP is discarded and sets `protocol_err`. Only reset clears it.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `add_req`=0, `rsp_valid`=0, `rsp_illegal`=0, `protocol_err`=0. All data registers, and therefore `add_a`, `add_b`, `add_rm`, `rsp_result`, `rsp_tag` and `rsp_fflags`, reset to 0.
- Legal request accepted at edge N:
  - `add_req`=1 during cycle N+1;
  - the adder presents `add_valid` during cycle N+2;
  - `rsp_valid`=1 from cycle N+3.
  - Latency is 3 cycles.
- Throughput:
  - Legal requests: 1 per 3 cycles when `rsp_ready` is held high.
  - Illegal requests: `rsp_valid` from N+1.
- Reset asserted mid-operation clears state immediately, with no response emitted. The adder shares `rst_n` (inverted) so no stray result follows.
- `frm` changes after acceptance do not affect an in-flight request.

## Structure
- Package `fpu_add_pkg`:
  - state enum;
  - RM encodings (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7);
  - FP field widths (exp 8, mant 23);
  - QNAN constant 32'h7FC0_0000;
  - fflags bit positions.
- Sub-module `fpu_add_classify`: combinational classification of one operand into {zero, inf, snan, qnan}, instantiated twice (A and effective B). It is reusable by other FPU issue stages.

## Test plan
- FADD 3FA00000 + 3FB00000, rm=000, tag=5:
  - `add_req` pulse one cycle after accept with `add_b`=3FB00000;
  - `rsp_valid` at +3 with the adder result 40280000, tag 5, fflags 0.
- FSUB 3FA00000 − 3FA00000, rm=111, frm=001:
  - `add_b`=BFA00000, `add_rm`=001;
  - response 00000000, NV=0.
- FADD 7F800000 + FF800000: NV=1. FSUB 7F800000 − 7F800000: NV=1. Operand 7F800001 (sNaN): NV=1. Operand 7FC00000 (qNaN): NV=0.
- rm=111 with frm=101:
  - `rsp_illegal`=1 at +1 and `add_req` never asserts;
  - same result with rm=110.
- Back-to-back requests, `rsp_ready` low for 4 cycles, then pulsed:
  - response held stable while `rsp_ready` is low;
  - second request accepted in the same cycle `rsp_ready`=1;
  - tags returned in order.
- Reset and protocol errors:
  - Assert `rst_n`=0 during WAIT: all outputs return to reset values asynchronously, and no response follows release.
  - Inject `add_valid` in IDLE: `protocol_err` sets and stays set until reset.
